decode_imm_ctrl: RTL

- Decode-stage controller that sits between the IF/ID instruction stream and the ID-stage immediate generator.
- Accepts instructions over a valid/ready handshake and classifies each opcode into the 3-bit immediate-format select.
- Buffers instructions in a 2-entry skid queue, so upstream backpressure timing is decoupled from the downstream stall.
- Presents the registered instruction and its select to the immediate generator and the ID/EX register, and supports pipeline flush.

---
 rtl/decode_imm_ctrl_if.sv | 29 ++
 rtl/decode_imm_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/decode_imm_ctrl_if.sv
// Valid/ready instruction stream between IF/ID and the decode-stage immediate controller.
// The master side feeds instructions and the downstream stall; the slave side is the controller.
interface decode_imm_ctrl_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              In_Valid;
    logic              In_Ready;
    logic [INST_W-1:0] In_Inst;
    logic [PC_W-1:0]   In_PC;
    logic              Flush;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [INST_W-1:0] Out_Inst;
    logic [PC_W-1:0]   Out_PC;
    logic [2:0]        ImmSel;
    logic              Illegal;
    logic [1:0]        Occupancy;

    modport master (
        output In_Valid, In_Inst, In_PC, Flush, Out_Ready,
        input  In_Ready, Out_Valid, Out_Inst, Out_PC, ImmSel, Illegal, Occupancy
    );

    modport slave (
        input  In_Valid, In_Inst, In_PC, Flush, Out_Ready,
        output In_Ready, Out_Valid, Out_Inst, Out_PC, ImmSel, Illegal, Occupancy
    );
endinterface

// File: rtl/decode_imm_ctrl.sv
// Decode-stage controller: classifies opcodes into the immediate-format select on entry and
// holds instructions in a 2-entry skid queue (head + skid) feeding the immediate generator.
module decode_imm_ctrl #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    decode_imm_ctrl_if.slave  bus
);
    localparam logic [2:0] SEL_I    = 3'b000;
    localparam logic [2:0] SEL_S    = 3'b001;
    localparam logic [2:0] SEL_B    = 3'b010;
    localparam logic [2:0] SEL_U    = 3'b011;
    localparam logic [2:0] SEL_J    = 3'b100;
    localparam logic [2:0] SEL_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Returns {illegal, imm_sel}; R-type and FENCE are legal but carry no immediate.
    function automatic logic [3:0] decode_opcode(input logic [6:0] opcode);
        logic [3:0] res;
        case (opcode)
            7'b0000011, 7'b0010011,
            7'b1100111, 7'b1110011: res = {1'b0, SEL_I};
            7'b0100011:             res = {1'b0, SEL_S};
            7'b1100011:             res = {1'b0, SEL_B};
            7'b0110111, 7'b0010111: res = {1'b0, SEL_U};
            7'b1101111:             res = {1'b0, SEL_J};
            7'b0110011, 7'b0001111: res = {1'b0, SEL_NONE};
            default:                res = {1'b1, SEL_NONE};
        endcase
        return res;
    endfunction

    state_t            state_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [1:0]        occupancy_r;
    logic [INST_W-1:0] head_inst_r;
    logic [PC_W-1:0]   head_pc_r;
    logic [2:0]        head_sel_r;
    logic              head_ill_r;
    logic [INST_W-1:0] skid_inst_r;
    logic [PC_W-1:0]   skid_pc_r;
    logic [2:0]        skid_sel_r;
    logic              skid_ill_r;

    logic [3:0]        dec_s;
    logic              in_fire_s;
    logic              out_fire_s;

    // Classify the incoming opcode so the select is stored with the entry.
    always_comb begin
        dec_s = decode_opcode(bus.In_Inst[6:0]);
    end

    assign in_fire_s  = bus.In_Valid & in_ready_r;
    assign out_fire_s = out_valid_r & bus.Out_Ready;

    assign bus.In_Ready  = in_ready_r;
    assign bus.Out_Valid = out_valid_r;
    assign bus.Occupancy = occupancy_r;
    assign bus.Out_Inst  = head_inst_r;
    assign bus.Out_PC    = head_pc_r;
    assign bus.ImmSel    = head_sel_r;
    assign bus.Illegal   = head_ill_r;

    // Queue state machine; handshake flags are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
            head_inst_r <= '0;
            head_pc_r   <= '0;
            head_sel_r  <= SEL_NONE;
            head_ill_r  <= 1'b0;
            skid_inst_r <= '0;
            skid_pc_r   <= '0;
            skid_sel_r  <= SEL_NONE;
            skid_ill_r  <= 1'b0;
        end else if (bus.Flush) begin
            // Payload is left stale; Out_Valid=0 makes it invisible.
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        head_inst_r <= bus.In_Inst;
                        head_pc_r   <= bus.In_PC;
                        head_sel_r  <= dec_s[2:0];
                        head_ill_r  <= dec_s[3];
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                        occupancy_r <= 2'd1;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        head_inst_r <= bus.In_Inst;
                        head_pc_r   <= bus.In_PC;
                        head_sel_r  <= dec_s[2:0];
                        head_ill_r  <= dec_s[3];
                    end else if (in_fire_s) begin
                        skid_inst_r <= bus.In_Inst;
                        skid_pc_r   <= bus.In_PC;
                        skid_sel_r  <= dec_s[2:0];
                        skid_ill_r  <= dec_s[3];
                        state_r     <= ST_TWO;
                        in_ready_r  <= 1'b0;
                        occupancy_r <= 2'd2;
                    end else if (out_fire_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        occupancy_r <= 2'd0;
                    end
                end
                ST_TWO: begin
                    // In_Ready is low here, so only the skid-to-head move can happen.
                    if (out_fire_s) begin
                        head_inst_r <= skid_inst_r;
                        head_pc_r   <= skid_pc_r;
                        head_sel_r  <= skid_sel_r;
                        head_ill_r  <= skid_ill_r;
                        state_r     <= ST_ONE;
                        in_ready_r  <= 1'b1;
                        occupancy_r <= 2'd1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    occupancy_r <= 2'd0;
                end
            endcase
        end
    end
endmodule
